// File: rtl/controller_pkg.sv
// Shared types, ALU function codes and width-independent field helpers for the
// multi-cycle controller.
package controller_pkg;

    typedef enum logic [7:0] {
        StInit   = 8'd0,
        StFetch  = 8'd1,
        StDecode = 8'd2,
        StLoadA  = 8'd3,
        StLoadB  = 8'd4,
        StStore  = 8'd5,
        StAdd    = 8'd6,
        StSub    = 8'd7,
        StBrz    = 8'd8,
        StHalt   = 8'd9
    } state_t;

    typedef enum logic [3:0] {
        OpNoop  = 4'd0,
        OpStore = 4'd1,
        OpLoad  = 4'd2,
        OpAdd   = 4'd3,
        OpSub   = 4'd4,
        OpHalt  = 4'd5,
        OpJump  = 4'd6,
        OpBrz   = 4'd7
    } opcode_t;

    localparam logic [3:0] AluPassA = 4'd0;
    localparam logic [3:0] AluAdd   = 4'd1;
    localparam logic [3:0] AluSub   = 4'd2;

    // Callers zero-extend the word to 64 bits and truncate the result to the field width.
    function automatic logic [63:0] get_field(input logic [63:0] word,
                                              input int unsigned lsb,
                                              input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (word >> lsb) & mask;
    endfunction

    function automatic logic [63:0] sext8(input logic [7:0] v);
        return {{56{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into opcode and operand
// fields, plus an illegal-opcode flag.
module instr_decoder
    import controller_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned D_ADDR_W = 8,
    parameter int unsigned R_ADDR_W = 4,
    parameter int unsigned I_ADDR_W = 7
) (
    input  logic [WIDTH-1:0]    ir_i,
    output opcode_t             op_o,
    output logic                illegal_o,
    output logic [R_ADDR_W-1:0] ra_o,
    output logic [R_ADDR_W-1:0] rb_o,
    output logic [R_ADDR_W-1:0] rd_o,
    output logic [D_ADDR_W-1:0] mem_addr_o,
    output logic [R_ADDR_W-1:0] mem_reg_o,
    output logic [I_ADDR_W-1:0] jump_target_o,
    output logic [7:0]          brz_off_o
);

    localparam int unsigned OpLsb = WIDTH - 4;
    localparam int unsigned RaLsb = OpLsb - R_ADDR_W;
    localparam int unsigned RbLsb = RaLsb - R_ADDR_W;
    localparam int unsigned RdLsb = RbLsb - R_ADDR_W;

    logic [63:0] ir64;
    logic [3:0]  op_raw;

    assign ir64   = 64'(ir_i);
    assign op_raw = 4'(get_field(ir64, OpLsb, 4));

    // Codes 8..15 all carry the top opcode bit set.
    assign illegal_o     = op_raw[3];
    assign op_o          = opcode_t'(op_raw);
    assign ra_o          = R_ADDR_W'(get_field(ir64, RaLsb, R_ADDR_W));
    assign rb_o          = R_ADDR_W'(get_field(ir64, RbLsb, R_ADDR_W));
    assign rd_o          = R_ADDR_W'(get_field(ir64, RdLsb, R_ADDR_W));
    assign mem_addr_o    = D_ADDR_W'(get_field(ir64, R_ADDR_W, D_ADDR_W));
    assign mem_reg_o     = R_ADDR_W'(get_field(ir64, 0, R_ADDR_W));
    assign jump_target_o = I_ADDR_W'(get_field(ir64, 0, I_ADDR_W));
    assign brz_off_o     = 8'(get_field(ir64, 0, 8));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM with handshaked instruction fetch, jump, branch-if-zero,
// halt and illegal-opcode detection. Holds the PC and IR.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned D_ADDR_W = 8,
    parameter int unsigned R_ADDR_W = 4,
    parameter int unsigned I_ADDR_W = 7
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                I_req,
    output logic [I_ADDR_W-1:0] I_addr,
    input  logic                I_ready,
    input  logic [WIDTH-1:0]    I_data,
    input  logic                ALU_zero,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic [3:0]          ALU_sel,
    output logic [WIDTH-1:0]    IR_Out,
    output logic [I_ADDR_W-1:0] PC_Out,
    output logic [7:0]          State_Out,
    output logic [7:0]          NextState_Out,
    output logic                Halted,
    output logic                Illegal
);

    state_t              state_q, state_d;
    logic [I_ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]    ir_q, ir_d;

    opcode_t             op;
    logic                op_illegal;
    logic [R_ADDR_W-1:0] ra, rb, rd, mem_reg;
    logic [D_ADDR_W-1:0] mem_addr;
    logic [I_ADDR_W-1:0] jump_target;
    logic [7:0]          brz_off;

    instr_decoder #(
        .WIDTH    (WIDTH),
        .D_ADDR_W (D_ADDR_W),
        .R_ADDR_W (R_ADDR_W),
        .I_ADDR_W (I_ADDR_W)
    ) u_decoder (
        .ir_i          (ir_q),
        .op_o          (op),
        .illegal_o     (op_illegal),
        .ra_o          (ra),
        .rb_o          (rb),
        .rd_o          (rd),
        .mem_addr_o    (mem_addr),
        .mem_reg_o     (mem_reg),
        .jump_target_o (jump_target),
        .brz_off_o     (brz_off)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        I_req     = 1'b0;
        D_addr    = '0;
        D_wr      = 1'b0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        ALU_sel   = AluPassA;
        Halted    = 1'b0;
        Illegal   = 1'b0;

        unique case (state_q)
            StInit: state_d = StFetch;
            StFetch: begin
                I_req = 1'b1;
                if (I_ready) begin
                    ir_d    = I_data;
                    pc_d    = pc_q + I_ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                RF_A_addr = ra;
                RF_B_addr = rb;
                state_d   = StFetch;
                if (op_illegal) begin
                    Illegal = 1'b1;
                end else begin
                    case (op)
                        OpStore: state_d = StStore;
                        OpLoad:  state_d = StLoadA;
                        OpAdd:   state_d = StAdd;
                        OpSub:   state_d = StSub;
                        OpHalt:  state_d = StHalt;
                        OpJump:  pc_d    = jump_target;
                        OpBrz:   state_d = StBrz;
                        default: state_d = StFetch;
                    endcase
                end
            end
            StLoadA: begin
                D_addr  = mem_addr;
                state_d = StLoadB;
            end
            StLoadB: begin
                D_addr    = mem_addr;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_addr = mem_reg;
                state_d   = StFetch;
            end
            StStore: begin
                D_addr    = mem_addr;
                RF_A_addr = mem_reg;
                D_wr      = 1'b1;
                state_d   = StFetch;
            end
            StAdd, StSub: begin
                RF_A_addr = ra;
                RF_B_addr = rb;
                ALU_sel   = (state_q == StAdd) ? AluAdd : AluSub;
                RF_W_en   = 1'b1;
                RF_W_addr = rd;
                state_d   = StFetch;
            end
            StBrz: begin
                RF_A_addr = ra;
                // PC already points past the branch, so the offset is relative to it.
                if (ALU_zero) pc_d = pc_q + I_ADDR_W'(sext8(brz_off));
                state_d = StFetch;
            end
            StHalt: Halted = 1'b1;
            default: state_d = StInit;
        endcase
    end

    assign I_addr        = pc_q;
    assign PC_Out        = pc_q;
    assign IR_Out        = ir_q;
    assign State_Out     = state_q;
    assign NextState_Out = state_d;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; outputs are sampled on
// the falling clock edge and inputs change there too.
module tb_multicycle_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        I_req;
    logic [6:0]  I_addr;
    logic        I_ready;
    logic [15:0] I_data;
    logic        ALU_zero;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_A_addr;
    logic [3:0]  RF_B_addr;
    logic [3:0]  ALU_sel;
    logic [15:0] IR_Out;
    logic [6:0]  PC_Out;
    logic [7:0]  State_Out;
    logic [7:0]  NextState_Out;
    logic        Halted;
    logic        Illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    multicycle_controller dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .I_req         (I_req),
        .I_addr        (I_addr),
        .I_ready       (I_ready),
        .I_data        (I_data),
        .ALU_zero      (ALU_zero),
        .D_addr        (D_addr),
        .D_wr          (D_wr),
        .RF_s          (RF_s),
        .RF_W_en       (RF_W_en),
        .RF_W_addr     (RF_W_addr),
        .RF_A_addr     (RF_A_addr),
        .RF_B_addr     (RF_B_addr),
        .ALU_sel       (ALU_sel),
        .IR_Out        (IR_Out),
        .PC_Out        (PC_Out),
        .State_Out     (State_Out),
        .NextState_Out (NextState_Out),
        .Halted        (Halted),
        .Illegal       (Illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Runs one instruction through a zero-wait fetch starting from FETCH; ends in DECODE.
    task automatic fetch(input logic [15:0] instr);
        I_data  = instr;
        I_ready = 1'b1;
        step();
    endtask

    initial begin
        Reset    = 1'b1;
        I_ready  = 1'b1;
        I_data   = 16'h3123;
        ALU_zero = 1'b0;

        // Reset state
        step();
        check_eq("rst_state", State_Out, 0);
        check_eq("rst_ireq", I_req, 0);
        check_eq("rst_pc", PC_Out, 0);
        check_eq("rst_ir", IR_Out, 0);
        check_eq("rst_halted", Halted, 0);
        check_eq("rst_wen", RF_W_en, 0);
        Reset = 1'b0;

        // ADD r3 = r1 + r2, state path 0,1,2,6,1
        step();
        check_eq("add_fetch_state", State_Out, 1);
        check_eq("add_fetch_ireq", I_req, 1);
        check_eq("add_fetch_iaddr", I_addr, 0);
        step();
        check_eq("add_dec_state", State_Out, 2);
        check_eq("add_dec_ir", IR_Out, 16'h3123);
        check_eq("add_dec_pc", PC_Out, 1);
        check_eq("add_dec_ra", RF_A_addr, 1);
        check_eq("add_dec_rb", RF_B_addr, 2);
        check_eq("add_dec_wen", RF_W_en, 0);
        step();
        check_eq("add_ex_state", State_Out, 6);
        check_eq("add_ex_wen", RF_W_en, 1);
        check_eq("add_ex_waddr", RF_W_addr, 3);
        check_eq("add_ex_alu", ALU_sel, 1);
        check_eq("add_ex_rfs", RF_s, 0);
        step();
        check_eq("add_back_state", State_Out, 1);
        check_eq("add_back_pc", PC_Out, 1);

        // Fetch wait states; IR must not move until the ready edge
        I_ready = 1'b0;
        I_data  = 16'h2A55;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wait_state", State_Out, 1);
            check_eq("wait_next", NextState_Out, 1);
            check_eq("wait_ireq", I_req, 1);
            check_eq("wait_iaddr", I_addr, 1);
            check_eq("wait_ir", IR_Out, 16'h3123);
        end

        // LOAD r5 <- mem[0xA5]
        fetch(16'h2A55);
        check_eq("ld_dec_state", State_Out, 2);
        check_eq("ld_dec_ir", IR_Out, 16'h2A55);
        check_eq("ld_dec_pc", PC_Out, 2);
        step();
        check_eq("ld_a_state", State_Out, 3);
        check_eq("ld_a_daddr", D_addr, 8'hA5);
        check_eq("ld_a_wen", RF_W_en, 0);
        check_eq("ld_a_rfs", RF_s, 0);
        step();
        check_eq("ld_b_state", State_Out, 4);
        check_eq("ld_b_daddr", D_addr, 8'hA5);
        check_eq("ld_b_rfs", RF_s, 1);
        check_eq("ld_b_wen", RF_W_en, 1);
        check_eq("ld_b_waddr", RF_W_addr, 5);
        check_eq("ld_b_dwr", D_wr, 0);
        step();
        check_eq("ld_back_state", State_Out, 1);

        // STORE mem[0x3C] <- r7
        fetch(16'h13C7);
        step();
        check_eq("st_state", State_Out, 5);
        check_eq("st_dwr", D_wr, 1);
        check_eq("st_daddr", D_addr, 8'h3C);
        check_eq("st_ra", RF_A_addr, 7);
        check_eq("st_wen", RF_W_en, 0);
        step();
        // SUB r6 = r4 - r5
        fetch(16'h4456);
        step();
        check_eq("sub_state", State_Out, 7);
        check_eq("sub_alu", ALU_sel, 2);
        check_eq("sub_waddr", RF_W_addr, 6);
        step();
        check_eq("sub_pc", PC_Out, 4);

        // JUMP to 10, then BRZ r1, -4 taken -> 7
        fetch(16'h600A);
        check_eq("jmp_dec_next", NextState_Out, 1);
        step();
        check_eq("jmp_pc", PC_Out, 10);
        check_eq("jmp_state", State_Out, 1);
        fetch(16'h71FC);
        check_eq("brz_dec_pc", PC_Out, 11);
        check_eq("brz_dec_ra", RF_A_addr, 1);
        check_eq("brz_dec_alu", ALU_sel, 0);
        ALU_zero = 1'b1;
        step();
        check_eq("brz_state", State_Out, 8);
        check_eq("brz_ra", RF_A_addr, 1);
        check_eq("brz_wen", RF_W_en, 0);
        step();
        check_eq("brz_taken_pc", PC_Out, 7);

        // BRZ not taken -> falls through to 11
        fetch(16'h600A);
        step();
        fetch(16'h71FC);
        ALU_zero = 1'b0;
        step();
        step();
        check_eq("brz_nt_pc", PC_Out, 11);

        // PC wrap on fetch at 127, then JUMP to 0
        fetch(16'h607F);
        step();
        check_eq("jmp127_pc", PC_Out, 127);
        fetch(16'h6000);
        check_eq("wrap_pc", PC_Out, 0);
        step();
        check_eq("jmp0_pc", PC_Out, 0);

        // Illegal opcode: one-cycle pulse, no writes, continues at PC+1
        fetch(16'hF000);
        check_eq("ill_state", State_Out, 2);
        check_eq("ill_pulse", Illegal, 1);
        check_eq("ill_wen", RF_W_en, 0);
        check_eq("ill_dwr", D_wr, 0);
        check_eq("ill_next", NextState_Out, 1);
        step();
        check_eq("ill_clear", Illegal, 0);
        check_eq("ill_fetch_state", State_Out, 1);
        check_eq("ill_fetch_addr", I_addr, 1);

        // HALT: held with no fetch requests
        fetch(16'h5000);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("halt_state", State_Out, 9);
            check_eq("halt_next", NextState_Out, 9);
            check_eq("halt_flag", Halted, 1);
            check_eq("halt_ireq", I_req, 0);
        end
        check_eq("halt_pc", PC_Out, 2);

        // Reset out of HALT restarts fetching at 0
        Reset = 1'b1;
        step();
        check_eq("hrst_state", State_Out, 0);
        check_eq("hrst_pc", PC_Out, 0);
        check_eq("hrst_halted", Halted, 0);
        Reset = 1'b0;
        step();
        check_eq("hrst_fetch", State_Out, 1);
        check_eq("hrst_ireq", I_req, 1);
        check_eq("hrst_iaddr", I_addr, 0);

        // Reset during a fetch wait abandons the fetch
        fetch(16'h0ABC);
        step();
        check_eq("noop_back", State_Out, 1);
        check_eq("noop_ir", IR_Out, 16'h0ABC);
        I_ready = 1'b0;
        I_data  = 16'h3123;
        step();
        step();
        Reset = 1'b1;
        step();
        check_eq("wrst_state", State_Out, 0);
        check_eq("wrst_ireq", I_req, 0);
        check_eq("wrst_pc", PC_Out, 0);
        check_eq("wrst_ir", IR_Out, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
